seq_det_arbiter: RTL and testbench

- Shares one serial sequence detector (seq_det-style: seq_in, clock, reset, det_o) among NREQ parallel-word requesters.
- Round-robin grant; the accepted word is latched and shifted MSB-first into the detector, one bit per clock.
- The detector is cleared before every word, so no detection spans two words.
- Detections are counted over the word's window and returned with the requester id on a valid/ready response port.

---
 rtl/seq_det_arbiter.sv | 108 ++++++++++
 tb/tb_seq_det_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter: round-robin sharing of one serial sequence detector among NREQ word requesters.
// Define SEQ_DET_ARBITER_STATS_EN to add the saturating stat_hits total of all reported counts.
module seq_det_arbiter #(
  parameter int NREQ = 2,
  parameter int W = 8,
  parameter int CNT_W = 4,
  parameter int DET_LAT = 1,
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              seq_out,
  output logic              det_rst,
  input  logic              det_i,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [CNT_W-1:0]  rsp_count,
  output logic              busy
`ifdef SEQ_DET_ARBITER_STATS_EN
  , output logic [15:0]     stat_hits
`endif
);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t state;
  logic [IDW-1:0] last, gnt;
  logic gnt_any;
  logic [W-1:0] word, sh;
  logic [31:0] k;
  logic [CNT_W-1:0] cnt;
  int d, best;
  // Priority distance from last+1 with wrap-around; the smallest distance wins.
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    best = NREQ;
    d = 0;
    word = '0;
    for (int j = 0; j < NREQ; j++) begin
      d = (j + NREQ - int'(last) - 1) % NREQ;
      if (req_valid[j] && d < best) begin
        best = d;
        gnt = IDW'(j);
        gnt_any = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++)
      if (gnt == IDW'(j)) word = req_data[j*W +: W];
  end
  assign req_ready = (!reset && state == IDLE && gnt_any) ? NREQ'(1) << gnt : '0;
  assign seq_out = state == SHIFT && sh[W-1];
  assign det_rst = reset || state == CLR;
  assign rsp_valid = state == DONE;
  assign rsp_count = cnt;
  assign busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last <= IDW'(NREQ - 1);
      sh <= '0;
      k <= '0;
      cnt <= '0;
      rsp_id <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          sh <= word;
          rsp_id <= gnt;
          last <= gnt;
          state <= CLR;
        end
        CLR: begin
          cnt <= '0;
          k <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sh <= sh << 1;
          k <= k + 32'd1;
          // The first DET_LAT detector outputs still reflect pre-word history.
          if (k >= DET_LAT && det_i) cnt <= cnt + CNT_W'(1);
          if (k == W - 1) begin
            k <= '0;
            state <= (DET_LAT > 0) ? DRAIN : DONE;
          end
        end
        DRAIN: begin
          k <= k + 32'd1;
          if (det_i) cnt <= cnt + CNT_W'(1);
          if (k == DET_LAT - 1) state <= DONE;
        end
        DONE: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SEQ_DET_ARBITER_STATS_EN
  logic [16:0] sum;
  assign sum = {1'b0, stat_hits} + 17'(cnt);
  always_ff @(posedge clock) begin
    if (reset) stat_hits <= '0;
    else if (state == DONE && rsp_ready) stat_hits <= sum[16] ? 16'hFFFF : sum[15:0];
  end
`endif
endmodule

// File: tb/tb_seq_det_arbiter.sv
// tb_seq_det_arbiter: directed bench with a behavioural overlapping Moore 1011 detector.
module tb_seq_det_arbiter;
  logic clock = 0, reset;
  logic [1:0] req_valid, req_ready;
  logic [15:0] req_data;
  logic seq_out, det_rst, det_i, rsp_valid, rsp_ready, busy;
  logic [0:0] rsp_id;
  logic [3:0] rsp_count;
`ifdef SEQ_DET_ARBITER_STATS_EN
  logic [15:0] stat_hits;
`endif
  int tests = 0, fails = 0;
  logic [2:0] ds;
  always #5 clock = ~clock;
  seq_det_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .seq_out(seq_out), .det_rst(det_rst), .det_i(det_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .busy(busy)
`ifdef SEQ_DET_ARBITER_STATS_EN
    , .stat_hits(stat_hits)
`endif
  );
  always_ff @(posedge clock) begin
    if (det_rst) ds <= 3'd0;
    else case (ds)
      3'd0: ds <= seq_out ? 3'd1 : 3'd0;
      3'd1: ds <= seq_out ? 3'd1 : 3'd2;
      3'd2: ds <= seq_out ? 3'd3 : 3'd0;
      3'd3: ds <= seq_out ? 3'd4 : 3'd2;
      default: ds <= seq_out ? 3'd1 : 3'd2;
    endcase
  end
  assign det_i = ds == 3'd4;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    #1 chk("det_rst_in_reset", 32'(det_rst), 1);
    reset = 0;
    @(negedge clock);
  endtask
  task automatic run_word(input int id, input logic [7:0] data, input int ecnt);
    logic [7:0] got = 0;
    int lat = 0, nrst = 0;
    req_data = id == 1 ? {data, 8'h00} : {8'h00, data};
    req_valid = id == 1 ? 2'b10 : 2'b01;
    #1 chk("grant", 32'(req_ready), id == 1 ? 2 : 1);
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clock);
      if (c == 1) req_valid = 0;
      #1;
      if (det_rst) nrst++;
      if (c >= 2 && c <= 9) got = {got[6:0], seq_out};
      if (rsp_valid) lat = c;
    end
    chk("latency", 32'(lat), 11);
    chk("serial_word", 32'(got), 32'(data));
    chk("det_rst_cycles", 32'(nrst), 1);
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_count", 32'(rsp_count), 32'(ecnt));
    @(negedge clock);
    #1 chk("idle_after_rsp", 32'(busy), 0);
  endtask
  initial begin
    logic [1:0] gr [4] = '{default: 0};
    int rid [4] = '{default: 9};
    int rcnt [4] = '{default: 9};
    int ng = 0, nr = 0;
    logic seen = 0;
    req_valid = 0;
    req_data = 0;
    rsp_ready = 1;
    do_reset();
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_seq_out", 32'(seq_out), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_count", 32'(rsp_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_det_rst", 32'(det_rst), 0);
    run_word(0, 8'b1011_0110, 2);
`ifdef SEQ_DET_ARBITER_STATS_EN
    chk("stat_after_1", 32'(stat_hits), 2);
`endif
    run_word(1, 8'h00, 0);
    run_word(0, 8'b0000_0101, 0);
    run_word(0, 8'b1000_0000, 0);
    do_reset();
`ifdef SEQ_DET_ARBITER_STATS_EN
    #1 chk("stat_after_reset", 32'(stat_hits), 0);
`endif
    req_data = {8'h00, 8'hB6};
    req_valid = 2'b11;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      #1;
      if (req_ready != 0 && ng < 4) begin
        gr[ng] = req_ready;
        ng++;
      end
      if (rsp_valid) begin
        rid[nr] = int'(rsp_id);
        rcnt[nr] = int'(rsp_count);
        nr++;
      end
      @(negedge clock);
      if (ng == 4) req_valid = 0;
    end
    chk("rr_grants", 32'(ng), 4);
    chk("rr_rsps", 32'(nr), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_order", 32'(gr[i]), i % 2 ? 2 : 1);
      chk("rr_rsp_id", 32'(rid[i]), i % 2);
      chk("rr_rsp_count", 32'(rcnt[i]), i % 2 ? 0 : 2);
    end
`ifdef SEQ_DET_ARBITER_STATS_EN
    chk("stat_after_rr", 32'(stat_hits), 4);
`endif
    rsp_ready = 0;
    req_data = {8'h00, 8'hB6};
    req_valid = 2'b01;
    #1 chk("bp_grant", 32'(req_ready), 1);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      req_valid = 0;
      #1 seen = rsp_valid;
    end
    chk("bp_reached_done", 32'(seen), 1);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_id", 32'(rsp_id), 0);
      chk("bp_rsp_count", 32'(rsp_count), 2);
      chk("bp_no_ready", 32'(req_ready), 0);
      @(negedge clock);
      #1;
    end
    rsp_ready = 1;
    @(negedge clock);
    #1 chk("bp_next_grant", 32'(req_ready), 2);
    @(negedge clock);
    req_valid = 0;
    repeat (4) @(negedge clock);
    #1 chk("busy_in_shift", 32'(busy), 1);
    reset = 1;
    @(negedge clock);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_det_rst", 32'(det_rst), 1);
    reset = 0;
    req_valid = 2'b11;
    #1 chk("post_reset_grant", 32'(req_ready), 1);
    @(negedge clock);
    req_valid = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
